div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 39 +++
 rtl/div_unit_step.sv | 24 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions: ALU control codes and divider state encoding.
package cpuDefine;

    localparam int DIV_W = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLT  = 5'd2,
        ALU_SLTU = 5'd3,
        ALU_AND  = 5'd4,
        ALU_OR   = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_NOR  = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_LUI  = 5'd11,
        ALU_MUL  = 5'd12,
        ALU_MULH = 5'd13,
        ALU_MULHU = 5'd14,
        ALU_DIV  = 5'd15,
        ALU_MOD  = 5'd16,
        ALU_DIVU = 5'd17,
        ALU_MODU = 5'd18
    } AluCtrl;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } DivState;

    function automatic logic [DIV_W-1:0] neg_if(input logic en,
                                                input logic [DIV_W-1:0] x);
        return en ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 division step: shift in a dividend bit, trial subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvs_i};

    always_comb begin
        q_o   = ~diff[WIDTH];
        rem_o = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/MOD/DIVU/MODU with start/busy/done.
// Optional DIV_EARLY_OUT_EN: skip CALC when the quotient is trivially zero or divisor is 0.
module div_unit
    import cpuDefine::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    DivState state, state_n;

    logic [4:0]       op_q;
    logic [WIDTH-1:0] dvd, dvs, rem, src1_q;
    logic             q_neg, r_neg, dz;
    logic [CW-1:0]    cnt;

    logic             div_op, sgn_op, accept, dz_i, early;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] st_rem, quo, qf, rf, fixed;
    logic             st_q, rem_op_q;

    assign div_op = (op_i == ALU_DIV) || (op_i == ALU_MOD) ||
                    (op_i == ALU_DIVU) || (op_i == ALU_MODU);
    assign sgn_op = (op_i == ALU_DIV) || (op_i == ALU_MOD);
    assign accept = start_i && div_op && !flush_i &&
                    (state == IDLE || state == DONE);
    assign dz_i   = (src2_i == '0);
    assign mag1   = neg_if(sgn_op && src1_i[WIDTH-1], src1_i);
    assign mag2   = neg_if(sgn_op && src2_i[WIDTH-1], src2_i);

`ifdef DIV_EARLY_OUT_EN
    logic rem_op_i;
    assign rem_op_i = (op_i == ALU_MOD) || (op_i == ALU_MODU);
    assign early    = dz_i || (mag2 > mag1);
`else
    assign early    = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem),
        .bit_i (dvd[WIDTH-1]),
        .dvs_i (dvs),
        .rem_o (st_rem),
        .q_o   (st_q)
    );

    assign rem_op_q = (op_q == ALU_MOD) || (op_q == ALU_MODU);
    assign quo      = {dvd[WIDTH-2:0], st_q};
    assign qf       = dz ? '1 : neg_if(q_neg, quo);
    assign rf       = dz ? src1_q : neg_if(r_neg, st_rem);
    assign fixed    = rem_op_q ? rf : qf;

    assign busy_o = (state == CALC);
    assign done_o = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = early ? DONE : CALC;
            CALC: if (cnt == '0) state_n = DONE;
            DONE: state_n = accept ? (early ? DONE : CALC) : IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            op_q     <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            src1_q   <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            cnt      <= '0;
            result_o <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q   <= op_i;
                dvd    <= mag1;
                dvs    <= mag2;
                rem    <= '0;
                src1_q <= src1_i;
                q_neg  <= sgn_op && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                r_neg  <= sgn_op && src1_i[WIDTH-1];
                dz     <= dz_i;
                cnt    <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
                if (early)
                    result_o <= rem_op_i ? src1_i : (dz_i ? '1 : '0);
`endif
            end else if (state == CALC && !flush_i) begin
                rem <= st_rem;
                dvd <= quo;
                cnt <= cnt - 1'b1;
                if (cnt == '0) result_o <= fixed;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, expected results queued at issue.
module tb_div_unit;
    import cpuDefine::*;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  op_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_exp = '0;

    div_unit #(.WIDTH(32)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic        s;
        logic [31:0] ma, mb;
        s  = (op == ALU_DIV) || (op == ALU_MOD);
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        return (b == 0 || mb > ma) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    always @(negedge aclk) begin
        if (!areset && done_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got result %h, expected no done", result_o);
            end else begin
                e = sb.pop_front();
                check(e.nm, result_o, e.res);
                check({e.nm, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string nm, input bit push);
        @(posedge aclk); #1;
        drive(op, a, b);
        if (push) begin
            sb.push_back('{nm, exp, cyc, exp_lat(op, a, b)});
            last_exp = exp;
        end
        @(posedge aclk); #1;
        start_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge aclk); #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(posedge aclk); #1;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string nm);
        issue(op, a, b, exp, nm, 1'b1);
        drain();
    endtask

    int t0;

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        areset = 1'b0;

        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b1);
        check("busy_after_e0", {31'd0, busy_o}, 32'd1);
        drain();
        run(ALU_MODU, 32'd100, 32'd7, 32'd2, "modu_100_7");
        run(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run(ALU_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "mod_m7_2");
        run(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run(ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "mod_ovf");
        run(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_dz");
        run(ALU_MODU, 32'd5, 32'd0, 32'd5, "modu_dz");
        run(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_dz_neg");
        run(ALU_MOD, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "mod_dz_neg");
        run(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1");
        run(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "div_100_m7");
        run(ALU_DIVU, 32'd3, 32'd10, 32'd0, "divu_3_10");
        run(ALU_MODU, 32'd3, 32'd10, 32'd3, "modu_3_10");

        issue(ALU_ADD, 32'd9, 32'd3, 32'd0, "non_div", 1'b0);
        repeat (40) @(posedge aclk);
        #1;
        check("non_div_idle", {31'd0, busy_o}, 32'd0);

        // Abort a long divide partway through
        issue(ALU_DIVU, 32'd1000, 32'd10, 32'd0, "flushed", 1'b0);
        t0 = cyc;
        repeat (8) @(posedge aclk);
        #1;
        flush_i = 1'b1;
        @(posedge aclk); #1;
        flush_i = 1'b0;
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        check("flush_result_held", result_o, last_exp);
        repeat (40) @(posedge aclk);
        #1;
        run(ALU_DIVU, 32'd9, 32'd3, 32'd3, "divu_9_3");

        // Start held while busy is ignored; start in DONE is taken at once
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, "orig_kept", 1'b1);
        t0 = cyc - 1;
        repeat (3) @(posedge aclk);
        #1;
        drive(ALU_DIVU, 32'd50, 32'd5);
        repeat (4) @(posedge aclk);
        #1;
        start_i = 1'b0;
        while (cyc < t0 + 33) begin
            @(posedge aclk); #1;
        end
        drive(ALU_DIVU, 32'd8, 32'd2);
        sb.push_back('{"b2b_8_2", 32'd4, cyc, 33});
        @(posedge aclk); #1;
        start_i = 1'b0;
        drain();

        issue(ALU_DIVU, 32'd100, 32'd7, 32'd0, "reset_mid", 1'b0);
        repeat (5) @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        check("midreset_done", {31'd0, done_o}, 32'd0);
        check("midreset_result", result_o, 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        run(ALU_MODU, 32'd17, 32'd5, 32'd2, "modu_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
